// File: rtl/alu_op_sequencer.sv
// Issuing-side controller for the combinational 32-bit ALU.
// Takes one opcode plus operands per request, drives the ALU control fields,
// waits for the ALU to settle, captures the result and returns it over a
// valid/ready response channel. Illegal opcodes answer immediately with an error.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | ready for a request; alu_* hold the last legal operation
//  SETTLE | ALU driven, counting down until alu_s may be captured
//  RESP   | response presented; held until the consumer takes it
module alu_op_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [4:0]       req_imm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [15:0]      op_count,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_c_0,
  output logic             alu_const_var,
  output logic             alu_shift_direction,
  output logic [1:0]       alu_function_class,
  output logic [1:0]       alu_logic_function,
  output logic [4:0]       alu_const_amount,
  input  logic [WIDTH-1:0] alu_s
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       accept;
  logic       legal;
  logic       rsp_fire;

  logic       dec_c_0;
  logic       dec_const_var;
  logic       dec_shift_direction;
  logic [1:0] dec_function_class;
  logic [1:0] dec_logic_function;

  // rst_n gates req_ready so nothing can handshake while reset is held
  assign req_ready = rst_n && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign legal     = (req_op <= 4'hA);
  assign rsp_fire  = rsp_valid && rsp_ready;

  // Opcode decode into ALU control fields; shifts always operate on b
  always_comb begin
    dec_c_0             = 1'b0;
    dec_const_var       = 1'b0;
    dec_shift_direction = 1'b0;
    dec_function_class  = 2'b00;
    dec_logic_function  = 2'b00;
    case (req_op)
      4'h0: ;
      4'h1: dec_shift_direction = 1'b1;
      4'h2: dec_const_var = 1'b1;
      4'h3: begin
        dec_const_var       = 1'b1;
        dec_shift_direction = 1'b1;
      end
      4'h4: dec_function_class = 2'b10;
      4'h5: begin
        dec_function_class = 2'b10;
        dec_c_0            = 1'b1;
      end
      4'h6: begin
        dec_function_class = 2'b01;
        dec_c_0            = 1'b1;
      end
      4'h7: dec_function_class = 2'b11;
      4'h8: begin
        dec_function_class = 2'b11;
        dec_logic_function = 2'b01;
      end
      4'h9: begin
        dec_function_class = 2'b11;
        dec_logic_function = 2'b10;
      end
      4'hA: begin
        dec_function_class = 2'b11;
        dec_logic_function = 2'b11;
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = legal ? SETTLE : RESP;
      SETTLE:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ALU drive registers: loaded only by a legal accept so an error leaves them untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a               <= '0;
      alu_b               <= '0;
      alu_c_0             <= 1'b0;
      alu_const_var       <= 1'b0;
      alu_shift_direction <= 1'b0;
      alu_function_class  <= 2'b00;
      alu_logic_function  <= 2'b00;
      alu_const_amount    <= 5'd0;
    end else if (accept && legal) begin
      alu_a               <= req_a;
      alu_b               <= req_b;
      alu_c_0             <= dec_c_0;
      alu_const_var       <= dec_const_var;
      alu_shift_direction <= dec_shift_direction;
      alu_function_class  <= dec_function_class;
      alu_logic_function  <= dec_logic_function;
      alu_const_amount    <= req_imm;
    end
  end

  // Settle down-counter; capture happens on its terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             cnt <= 4'd0;
    else if (accept && legal)               cnt <= CNT_LOAD;
    else if (state == SETTLE && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  // Response payload: error answer on illegal accept, ALU result at end of settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (accept && !legal) begin
      rsp_data <= '0;
      rsp_err  <= 1'b1;
    end else if (state == SETTLE && cnt == 4'd0) begin
      rsp_data <= alu_s;
      rsp_err  <= 1'b0;
    end
  end

  // Completed-response counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        op_count <= 16'd0;
    else if (rsp_fire) op_count <= op_count + 16'd1;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a stand-in ALU, a transaction-level
// reference model, a per-cycle compare process, directed and random stimulus.
module tb_alu_op_sequencer;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [4:0]  req_imm = 5'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [15:0] op_count;
  logic [31:0] alu_a, alu_b;
  logic        alu_c_0, alu_const_var, alu_shift_direction;
  logic [1:0]  alu_function_class, alu_logic_function;
  logic [4:0]  alu_const_amount;
  logic [31:0] alu_s;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer #(.WIDTH(32), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_imm(req_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .op_count(op_count),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c_0(alu_c_0), .alu_const_var(alu_const_var),
    .alu_shift_direction(alu_shift_direction), .alu_function_class(alu_function_class),
    .alu_logic_function(alu_logic_function), .alu_const_amount(alu_const_amount),
    .alu_s(alu_s)
  );

  always #5 clk = ~clk;

  // Stand-in for the combinational ALU, driven purely by its control fields
  always_comb begin
    logic [4:0] amt;
    amt   = alu_const_var ? alu_a[4:0] : alu_const_amount;
    alu_s = 32'd0;
    case (alu_function_class)
      2'b00: alu_s = alu_shift_direction ? (alu_b >> amt) : (alu_b << amt);
      2'b01: alu_s = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      2'b10: alu_s = alu_c_0 ? (alu_a - alu_b) : (alu_a + alu_b);
      default: case (alu_logic_function)
        2'b00:   alu_s = alu_a & alu_b;
        2'b01:   alu_s = alu_a | alu_b;
        2'b10:   alu_s = alu_a ^ alu_b;
        default: alu_s = ~(alu_a | alu_b);
      endcase
    endcase
  end

  // What an opcode means, straight from the opcode table
  function automatic logic [31:0] ref_result(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                             logic [4:0] imm);
    case (op)
      4'd0:  return b << imm;
      4'd1:  return b >> imm;
      4'd2:  return b << a[4:0];
      4'd3:  return b >> a[4:0];
      4'd4:  return a + b;
      4'd5:  return a - b;
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return a & b;
      4'd8:  return a | b;
      4'd9:  return a ^ b;
      4'd10: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: busy from accept until the response is taken;
  // response appears m_wait edges after accept
  logic        m_busy;
  int          m_wait;
  logic [31:0] m_data, m_a, m_b;
  logic        m_err;
  logic [15:0] m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_wait <= 0; m_data <= 32'd0; m_err <= 1'b0;
      m_count <= 16'd0; m_a <= 32'd0; m_b <= 32'd0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy <= 1'b1;
        if (req_op <= 4'd10) begin
          m_a    <= req_a;
          m_b    <= req_b;
          m_data <= ref_result(req_op, req_a, req_b, req_imm);
          m_err  <= 1'b0;
          m_wait <= SETTLE;
        end else begin
          m_data <= 32'd0;
          m_err  <= 1'b1;
          m_wait <= 0;
        end
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
    end else if (rsp_ready) begin
      m_busy  <= 1'b0;
      m_count <= m_count + 16'd1;
    end
  end

  // Per-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    chk("req_ready", {31'd0, req_ready}, {31'd0, rst_n && !m_busy});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_busy && m_wait == 0});
    chk("op_count", {16'd0, op_count}, {16'd0, m_count});
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    if (m_busy && m_wait == 0) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
    end
  end

  // One request/response with literal expectations on result and latency
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] imm, input logic [31:0] exp_data,
                        input logic exp_err, input int exp_lat, input string name);
    int n;
    int k;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_imm = imm;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL %s_accept_timeout: got no req_ready expected req_ready", name);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_latency"}, k, exp_lat);
    chk({name, "_data"}, rsp_data, exp_data);
    chk({name, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // reset state
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_alu_class", {30'd0, alu_function_class}, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    rsp_ready = 1'b1;
    run_op(4'd4, 32'd19, 32'd55, 5'd0, 32'd74, 1'b0, 2, "add");
    run_op(4'd5, 32'd59, 32'd38, 5'd0, 32'd21, 1'b0, 2, "sub");
    run_op(4'd6, 32'd39, 32'd136, 5'd0, 32'd1, 1'b0, 2, "slt_lt");
    run_op(4'd6, 32'd136, 32'd39, 5'd0, 32'd0, 1'b0, 2, "slt_ge");
    run_op(4'd3, 32'd9, 32'd112, 5'd0, 32'd0, 1'b0, 2, "srl_var");
    run_op(4'd0, 32'd0, 32'd456, 5'd7, 32'd58368, 1'b0, 2, "sll_imm");
    run_op(4'd7, 32'd656, 32'd218, 5'd0, 32'd144, 1'b0, 2, "and");
    run_op(4'hC, 32'd5, 32'd6, 5'd0, 32'd0, 1'b1, 0, "illegal");
    chk("illegal_alu_a", alu_a, 32'd656);
    chk("illegal_alu_b", alu_b, 32'd218);
    chk("illegal_count", {16'd0, op_count}, 32'd8);
    run_op(4'd10, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 2, "nor");

    // backpressure with a second request waiting
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd4; req_a = 32'd100; req_b = 32'd23;
    @(posedge clk); #1;
    req_op = 4'd5; req_a = 32'd50; req_b = 32'd8;
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_data", rsp_data, 32'd123);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_count", {16'd0, op_count}, 32'd10);
    @(negedge clk);
    chk("bp_second_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("bp_second_data", rsp_data, 32'd42);
    @(posedge clk); #1;

    // async reset while settling
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd4; req_a = 32'd7; req_b = 32'd8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_count", {16'd0, op_count}, 32'd0);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    run_op(4'd4, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 2, "post_rst_add");
    chk("post_rst_count", {16'd0, op_count}, 32'd1);

    // random traffic checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = 4'($urandom_range(0, 15));
      req_a     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 300));
      req_b     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 300));
      req_imm   = 5'($urandom_range(0, 31));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
